// File: rtl/count_share_arbiter_pkg.sv
// Shared types, default sizes and the round-robin search used by the
// counter-sharing arbiter.
package count_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Walks offsets from the far end back to zero so the nearest set bit at or after ptr wins.
    function automatic rr_pick_t rr_search(input logic [7:0] req, input logic [2:0] ptr,
                                           input int nreq);
        rr_pick_t   pick;
        int         pos;
        logic [2:0] pos_b;
        pick.valid = 1'b0;
        pick.idx   = 3'd0;
        for (int k = NREQ_MAX - 1; k >= 0; k--) begin
            if (k < nreq) begin
                pos = int'(ptr) + k;
                if (pos >= nreq) begin
                    pos = pos - nreq;
                end else begin
                    pos = pos;
                end
                pos_b = 3'(pos);
                if (req[pos_b]) begin
                    pick.valid = 1'b1;
                    pick.idx   = pos_b;
                end else begin
                    pick = pick;
                end
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/count_share_arbiter_if.sv
// Client-side bundle of the counter-sharing arbiter: requests and lengths in,
// grants, completions and the live counter value out.
interface count_share_arbiter_if
    import count_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) ();

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic              tick;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      cnt;

    modport master (output req, len, tick, input gnt, done, busy, cnt);
    modport slave  (input req, len, tick, output gnt, done, busy, cnt);

endinterface

// File: rtl/count_share_arbiter_sync_down_counter.sv
// Loadable W-bit down-counter that saturates at zero; kept separate so the
// shared datapath can be replaced by another counter implementation.
module sync_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Counter register: load wins over decrement, and zero never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/count_share_arbiter.sv
// Round-robin owner of one shared down-counter: grants it to a requester,
// counts that requester's length on tick, then pulses its done.
module count_share_arbiter
    import count_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    count_share_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic            cnt_load_s;
    logic [W-1:0]    cnt_load_val_s;
    logic            cnt_en_s;
    logic [W-1:0]    cnt_s;
    logic            cnt_zero_s;
    logic [7:0]      req_pad_s;
    rr_pick_t        pick_s;
    logic [IW-1:0]   pick_idx_s;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return {IW{1'b0}};
        end else begin
            return i + {{(IW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Widen the request vector to the search function's fixed port size.
    always_comb begin
        req_pad_s             = 8'd0;
        req_pad_s[NREQ-1:0]   = bus.req;
    end

    assign pick_s     = rr_search(req_pad_s, 3'(ptr_q), NREQ);
    assign pick_idx_s = IW'(pick_s.idx);

    sync_down_counter #(.W(W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .en_i       (cnt_en_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, winner/pointer bookkeeping and counter control; an abort reloads zero so IDLE shows cnt=0.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {W{1'b0}};
        cnt_en_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_s.valid) begin
                    state_d        = ST_COUNT;
                    idx_d          = pick_idx_s;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = bus.len[pick_idx_s*W +: W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!bus.req[idx_q]) begin
                    state_d    = ST_IDLE;
                    ptr_d      = next_ptr(idx_q);
                    cnt_load_s = 1'b1;
                end else if (cnt_zero_s) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_en_s = bus.tick;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = next_ptr(idx_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        gnt_d  = {NREQ{1'b0}};
        done_d = {NREQ{1'b0}};
        busy_d = 1'b0;
        case (state_d)
            ST_COUNT: begin
                gnt_d  = {{(NREQ-1){1'b0}}, 1'b1} << idx_d;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_d;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Pointer, winner index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= {IW{1'b0}};
            idx_q  <= {IW{1'b0}};
            gnt_q  <= {NREQ{1'b0}};
            done_q <= {NREQ{1'b0}};
            busy_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            idx_q  <= idx_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.cnt  = cnt_s;

endmodule

// File: tb/tb_count_share_arbiter.sv
// Scoreboard bench for count_share_arbiter: each scenario queues per-cycle
// stimulus with the outputs expected after the following clock edge.
module tb_count_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    count_share_arbiter_if #(.NREQ(4), .W(4)) bus ();

    count_share_arbiter #(.NREQ(4), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       tk;
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
        logic [3:0] c;
    } cyc_t;

    cyc_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void push(input logic r, input logic [3:0] rq, input logic tk,
                                 input logic [3:0] g, input logic [3:0] d,
                                 input logic b, input logic [3:0] c);
        cyc_t e;
        e.r = r; e.rq = rq; e.tk = tk; e.g = g; e.d = d; e.b = b; e.c = c;
        sb_q.push_back(e);
    endfunction

    task automatic test_reset();
        cyc_t e;
        bus.len = 16'h0000;
        push(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL reset: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_single();
        cyc_t e;
        bus.len = {4'd0, 4'd0, 4'd0, 4'd3};
        push(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd3);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd2);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd0);
        push(1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 4'd0);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL single: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_round_robin();
        cyc_t       e;
        logic [3:0] pend;
        logic [3:0] oh;
        bus.len = {4'd1, 4'd1, 4'd1, 4'd1};
        push(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        for (int rnd = 0; rnd < 2; rnd++) begin
            pend = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                oh = 4'b0001 << i;
                push(1'b0, pend, 1'b1, oh, 4'b0000, 1'b1, 4'd1);
                push(1'b0, pend, 1'b1, oh, 4'b0000, 1'b1, 4'd0);
                push(1'b0, pend, 1'b1, 4'b0000, oh, 1'b1, 4'd0);
                pend = pend & ~oh;
                push(1'b0, pend, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
            end
            push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL round_robin: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_tick_len0();
        cyc_t e;
        bus.len = {4'd1, 4'd0, 4'd2, 4'd1};
        push(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 4'd0);
        push(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 4'd0);
        push(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd2);
        push(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd0);
        push(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'd0);
        push(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL tick_len0: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_abort();
        cyc_t e;
        bus.len = {4'd1, 4'd1, 4'd5, 4'd1};
        push(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd5);
        push(1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd4);
        push(1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd3);
        push(1'b0, 4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b1101, 1'b1, 4'b0100, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd1);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL abort: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        cyc_t e;
        bus.len = {4'd4, 4'd4, 4'd4, 4'd4};
        push(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 4'd4);
        push(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 4'd3);
        push(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 4'd2);
        push(1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd4);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL reset_mid_count: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    task automatic test_max_len();
        cyc_t       e;
        logic [3:0] cv;
        bus.len = {4'd0, 4'd0, 4'd0, 4'd15};
        push(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd15);
        for (int k = 1; k <= 15; k++) begin
            cv = 4'(15 - k);
            push(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, cv);
        end
        push(1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 4'd0);
        push(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rst = e.r; bus.req = e.rq; bus.tick = e.tk;
            @(posedge clk); #1;
            checks++;
            if ({bus.gnt, bus.done, bus.busy, bus.cnt} !== {e.g, e.d, e.b, e.c}) begin
                failures++;
                $display("FAIL max_len: got gnt=%b done=%b busy=%b cnt=%0d want gnt=%b done=%b busy=%b cnt=%0d",
                         bus.gnt, bus.done, bus.busy, bus.cnt, e.g, e.d, e.b, e.c);
            end
        end
    endtask

    initial begin
        bus.req  = 4'b0000;
        bus.len  = 16'h0000;
        bus.tick = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_round_robin();
        test_tick_len0();
        test_abort();
        test_reset_mid_count();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_share_arbiter.md
# count_share_arbiter

Round-robin controller that shares one W-bit down-counter among NREQ requesters needing a timed delay of a requested number of ticks. It grants the counter to one requester at a time, loads that requester's length, and decrements on each `tick`. On expiry it pulses that requester's `done`. It sits between the client blocks and the team's counter datapath, replacing one private counter per client.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 4: counter / length width
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level; held until `done` or deliberately dropped (abort)
- len  in  NREQ*W  per-requester length; slice i = len[i*W +: W]; sampled only at grant
- tick  in  1  count enable; decrement permitted only in cycles with tick=1
- gnt  out  NREQ  one-hot grant, registered; all-zero when idle
- done  out  NREQ  one-cycle completion pulse to the granted requester, registered
- busy  out  1  high in COUNT and DONE
- cnt  out  W  current counter value, registered

## Operation
- Reset values: state IDLE, gnt=0, done=0, busy=0, cnt=0, round-robin pointer ptr=0.
- The FSM has three states: IDLE, COUNT and DONE.
- IDLE, when req≠0:
  - The winner idx is the first set req bit searching ptr, ptr+1, … mod NREQ.
  - Next cycle: state COUNT, gnt=onehot(idx), cnt=len[idx], busy=1.
- IDLE, when req=0: remain in IDLE with all outputs zero.
- COUNT:
  - If req[idx]=0, abort: go to IDLE next cycle, gnt=0, busy=0, no done, ptr=idx+1 mod NREQ. Abort takes priority over expiry in the same cycle.
  - Else if cnt=0: go to DONE next cycle.
  - Else if tick=1: cnt=cnt-1.
  - Else: hold cnt.
- DONE: gnt=0, done[idx]=1, busy=1, ptr=idx+1 mod NREQ. Next cycle: IDLE.
- len=0: the requester is granted, cnt=0, and DONE follows on the very next cycle, regardless of tick.
- Arithmetic:
  - cnt never decrements below 0; it is unsigned W-bit and never wraps.
  - ptr wrap-around: NREQ-1 → 0.
- Changes to req bits of non-granted requesters during COUNT have no effect; they are arbitrated at the next IDLE.
- A requester still asserting req in the IDLE cycle after its DONE is treated as a new request, but ranks last because ptr has moved past it.
- Reset mid-operation (any state): next cycle all outputs return to reset values, no done pulse, ptr=0.

## Timing
- Grant latency: req seen in IDLE at cycle n → gnt and cnt=len valid at n+1.
- With tick=1 every cycle, grant at cycle g, length L: cnt=L-k at g+k, cnt=0 at g+L, done at g+L+1, IDLE at g+L+2.
- Back-to-back service: minimum 2 cycles between one done and the next gnt.
  - DONE cycle, then IDLE cycle, then grant.
- tick gaps stretch COUNT one cycle per tick=0 cycle while cnt>0. tick has no effect when cnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `count_share_pkg`:
  - FSM state typedef (IDLE/COUNT/DONE, 2-bit encoding).
  - Default NREQ/W constants.
  - Round-robin search function: (req, ptr) → idx, valid.
- One sub-module, `sync_down_counter`: W-bit register with load, load value, enable and zero flag.
  - Synchronous, clk/rst.
  - Holds the shared datapath so it can later be swapped for the team's counter implementation.
- The top level contains only the FSM, ptr register, idx register and output registers.

## Test plan
- Reset, then single request: NREQ=4, W=4, req=0001, len0=3, tick=1 → gnt=0001 at cycle 1, cnt 3,2,1,0 over cycles 1-4, done=0001 at cycle 5, gnt=0 and busy=0 at cycle 6.
- Round-robin fairness: req=1111 held, all len=1, requesters drop req after their done → grants in order 0,1,2,3. Then req=1111 again → order resumes at 0 (ptr wrapped from 3).
- Tick gating and len=0: len2=0 → done at grant+1 with tick=0. len1=2 with tick pattern 1,0,0,1 → done delayed by the 2 idle ticks.
- Abort: requester 1 granted with len=5, req[1] dropped when cnt=3 → no done pulse, IDLE next cycle, next grant goes to requester 2 if pending, else 3, else 0.
- Reset mid-COUNT: rst asserted at cnt=2 → next cycle gnt=0, done=0, busy=0, cnt=0. With req=1111 after reset, the first grant goes to requester 0.
- Max length: len=15 (all ones) → exactly 15 decrements and no wrap; done at grant+16 with continuous tick.
